// File: rtl/tail_input_sequencer_if.sv
// Handshake bundle for the tail-light input conditioner: raw controls in,
// conditioned controls and script status out.
interface tail_input_sequencer_if;
  logic       tick;
  logic       auto_en;
  logic       key1_n;
  logic [2:0] sw_raw;
  logic       key1_out;
  logic [2:0] sw_out;
  logic [2:0] step;
  logic       auto_active;

  modport master (
    output tick, auto_en, key1_n, sw_raw,
    input  key1_out, sw_out, step, auto_active
  );

  modport slave (
    input  tick, auto_en, key1_n, sw_raw,
    output key1_out, sw_out, step, auto_active
  );
endinterface

// File: rtl/tail_input_sequencer.sv
// Synchronizes and debounces the raw key/switch inputs, or replays a fixed
// six-step script while auto mode is selected.
//
// state     | meaning
// ST_MANUAL | outputs follow the debounced inputs; step and hold counter parked at 0
// ST_AUTO   | outputs follow the script table; step advances every STEP_TICKS ticks
module tail_input_sequencer #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int STEP_TICKS     = 8
) (
  input logic                    clock,
  input logic                    reset_n,
  tail_input_sequencer_if.slave  bus
);

  typedef enum logic {ST_MANUAL, ST_AUTO} state_t;

  state_t     r_state;
  logic       r_auto_active;
  logic [2:0] r_step;
  logic [7:0] r_hold;

  logic       r_auto_s1, r_auto_s2;
  logic       r_key_s1, r_key_s2;
  logic [2:0] r_sw_s1, r_sw_s2;

  logic [3:0] r_stable, r_cand, r_n;
  logic [3:0] r_out;

  logic [3:0] w_v;
  logic [3:0] w_n_inc;
  logic       w_hold_last;
  logic [3:0] w_tbl;

  // Two-flop synchronizers; the key idles high so its flops reset to 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_auto_s1 <= 1'b0;
      r_auto_s2 <= 1'b0;
      r_key_s1  <= 1'b1;
      r_key_s2  <= 1'b1;
      r_sw_s1   <= 3'b000;
      r_sw_s2   <= 3'b000;
    end else begin
      r_auto_s1 <= bus.auto_en;
      r_auto_s2 <= r_auto_s1;
      r_key_s1  <= bus.key1_n;
      r_key_s2  <= r_key_s1;
      r_sw_s1   <= bus.sw_raw;
      r_sw_s2   <= r_sw_s1;
    end
  end

  assign w_v     = {r_sw_s2, r_key_s2};
  assign w_n_inc = r_n + 4'd1;

  // Debouncer keeps running in auto mode so the stable value is fresh on exit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stable <= 4'b0001;
      r_cand   <= 4'b0001;
      r_n      <= 4'd0;
    end else if (w_v == r_stable) begin
      r_cand <= r_stable;
      r_n    <= 4'd0;
    end else if (w_v != r_cand) begin
      r_cand <= w_v;
      r_n    <= 4'd0;
    end else if (bus.tick) begin
      if (w_n_inc == 4'(DEBOUNCE_TICKS)) begin
        r_stable <= r_cand;
        r_n      <= 4'd0;
      end else begin
        r_n <= w_n_inc;
      end
    end
  end

  assign w_hold_last = (r_hold == 8'(STEP_TICKS - 1));

  // Counting uses the registered mode, so the rising clock only clears and
  // any coincident tick is dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_MANUAL;
      r_auto_active <= 1'b0;
      r_step        <= 3'd0;
      r_hold        <= 8'd0;
    end else begin
      r_auto_active <= r_auto_s2;
      case (r_state)
        ST_MANUAL: begin
          r_step <= 3'd0;
          r_hold <= 8'd0;
          if (r_auto_s2) r_state <= ST_AUTO;
        end
        ST_AUTO: begin
          if (!r_auto_s2) r_state <= ST_MANUAL;
          if (r_step > 3'd5) begin
            r_step <= 3'd0;
            r_hold <= 8'd0;
          end else if (bus.tick) begin
            if (w_hold_last) begin
              r_hold <= 8'd0;
              r_step <= (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
            end else begin
              r_hold <= r_hold + 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_tbl = 4'b0001;
    case (r_step)
      3'd0:    w_tbl = {3'b000, 1'b1};
      3'd1:    w_tbl = {3'b001, 1'b1};
      3'd2:    w_tbl = {3'b010, 1'b1};
      3'd3:    w_tbl = {3'b100, 1'b1};
      3'd4:    w_tbl = {3'b000, 1'b0};
      3'd5:    w_tbl = {3'b011, 1'b1};
      default: w_tbl = {3'b000, 1'b1};
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out <= 4'b0001;
    end else begin
      r_out <= r_auto_active ? w_tbl : r_stable;
    end
  end

  assign bus.key1_out    = r_out[0];
  assign bus.sw_out      = r_out[3:1];
  assign bus.step        = r_step;
  assign bus.auto_active = r_auto_active;

endmodule

// File: tb/tb_tail_input_sequencer.sv
// Directed bench for tail_input_sequencer: debounce latency, bounce rejection,
// script playback, auto exit and reset during playback.
module tb_tail_input_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  tail_input_sequencer_if bus ();

  tail_input_sequencer #(
    .DEBOUNCE_TICKS (4),
    .STEP_TICKS     (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int first;

  // {sw, key1} per script step, written out by hand: 0001,0011,0101,1001,0000,0111
  int exp_tbl [6] = '{1, 3, 5, 9, 0, 7};

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; tick is seen by exactly one posedge.
  task automatic cyc(input bit t);
    bus.tick = t;
    @(negedge clock);
    bus.tick = 1'b0;
  endtask

  function automatic int outv();
    return int'({bus.sw_out, bus.key1_out});
  endfunction

  initial begin
    bus.tick    = 1'b0;
    bus.auto_en = 1'b0;
    bus.key1_n  = 1'b1;
    bus.sw_raw  = 3'b000;
    reset_n     = 1'b0;
    @(negedge clock);
    @(negedge clock);

    chk("rst_key1", int'(bus.key1_out), 1);
    chk("rst_sw", int'(bus.sw_out), 0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_active", int'(bus.auto_active), 0);

    reset_n = 1'b1;
    repeat (4) cyc(1'b1);
    chk("idle_out", outv(), 1);

    // key pressed, tick every 4 clocks: sync 2, capture 1, 4 ticks to P16, output P17
    bus.key1_n = 1'b0;
    first = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(i % 4 == 0);
      if (first == 0 && bus.key1_out == 1'b0) first = i;
    end
    chk("key1_fall_clk", first, 17);

    bus.key1_n = 1'b1;
    repeat (12) cyc(1'b1);
    chk("key1_release", int'(bus.key1_out), 1);

    // bounce 001/000 every 2 clocks, settled on 001 from clock 9 -> out at 16
    first = 0;
    for (int i = 1; i <= 24; i++) begin
      bus.sw_raw = ((((i - 1) / 2) % 2) == 0 || i >= 9) ? 3'b001 : 3'b000;
      cyc(1'b1);
      if (first == 0 && bus.sw_out == 3'b001) first = i;
    end
    chk("sw_bounce_clk", first, 16);
    chk("sw_settled", int'(bus.sw_out), 1);

    bus.sw_raw = 3'b010;
    repeat (12) cyc(1'b1);
    chk("sw_manual_010", outv(), 5);

    // full playback, tick every clock
    bus.auto_en = 1'b1;
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(1'b1);
      if (first == 0 && bus.auto_active == 1'b1) first = i;
      if (i == 3)  chk("out_at_rise", outv(), 5);
      if (i == 4)  chk("out_step0", outv(), exp_tbl[0]);
      if (i == 10) chk("step0_hold", int'(bus.step), 0);
      if (i >= 11 && i <= 51 && (i - 11) % 8 == 0)
        chk("step_seq", int'(bus.step), ((i - 11) / 8 + 1) % 6);
      if (i >= 12 && i <= 52 && (i - 12) % 8 == 0)
        chk("out_seq", outv(), exp_tbl[((i - 12) / 8 + 1) % 6]);
    end
    chk("active_rise_clk", first, 3);

    bus.auto_en = 1'b0;
    repeat (6) cyc(1'b1);
    chk("exitA_active", int'(bus.auto_active), 0);
    chk("exitA_step", int'(bus.step), 0);
    chk("exitA_out", outv(), 5);

    // rise coincident with a tick, then drop auto_en during step 3
    bus.auto_en = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      if (i == 28) bus.auto_en = 1'b0;
      cyc(1'b1);
      if (i == 3) begin
        chk("B_rise_active", int'(bus.auto_active), 1);
        chk("B_rise_step", int'(bus.step), 0);
      end
      if (i == 10) chk("B_step0_last", int'(bus.step), 0);
      if (i == 11) chk("B_step1", int'(bus.step), 1);
      if (i == 27) chk("B_step3", int'(bus.step), 3);
      if (i == 29) chk("B_active_hold", int'(bus.auto_active), 1);
      if (i == 30) begin
        chk("B_active_fall", int'(bus.auto_active), 0);
        chk("B_out_step3", int'(bus.sw_out), 4);
      end
      if (i == 31) begin
        chk("B_sw_after", int'(bus.sw_out), 2);
        chk("B_key_after", int'(bus.key1_out), 1);
        chk("B_step_after", int'(bus.step), 0);
      end
    end

    repeat (4) cyc(1'b1);

    // one-clock reset during step 4 with auto_en still high
    bus.auto_en = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      reset_n = (i == 37) ? 1'b0 : 1'b1;
      cyc(1'b1);
      if (i == 36) chk("C_step4", int'(bus.step), 4);
      if (i == 37) begin
        chk("C_rst_key1", int'(bus.key1_out), 1);
        chk("C_rst_sw", int'(bus.sw_out), 0);
        chk("C_rst_step", int'(bus.step), 0);
        chk("C_rst_active", int'(bus.auto_active), 0);
      end
      if (i == 39) chk("C_active_low", int'(bus.auto_active), 0);
      if (i == 40) chk("C_active_rise", int'(bus.auto_active), 1);
      if (i == 41) begin
        chk("C_step_restart", int'(bus.step), 0);
        chk("C_out_step0", outv(), exp_tbl[0]);
      end
      if (i == 47) chk("C_step0_last", int'(bus.step), 0);
      if (i == 48) chk("C_step1", int'(bus.step), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
